// File: rtl/l2_cache_pkg.sv
// l2_cache_pkg: shared types and helpers for the 2-way L2 cache.
//   state_t    : controller states (S_IDLE, S_WB, S_FILL)
//   NUM_WAYS   : associativity
//   victim_sel : replacement choice for a set
package l2_cache_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WB   = 2'd1,
        S_FILL = 2'd2
    } state_t;

    localparam int NUM_WAYS = 2;

    // Prefer an empty way (way0 first) before evicting the LRU way.
    function automatic logic victim_sel(input logic i_valid0,
                                        input logic i_valid1,
                                        input logic i_lru);
        if (!i_valid0)      return 1'b0;
        else if (!i_valid1) return 1'b1;
        else                return i_lru;
    endfunction

endpackage

// File: rtl/l2_cache_2way_if.sv
// l2_cache_2way_if: L1-side and memory-side line bus of the L2 cache.
//   slave  modport : the cache (takes L1 requests, drives memory requests)
//   master modport : the environment (L1 requester + memory)
//   L1 side : l2_read, l2_write, l2_addr, l2_wdata -> l2_ready, l2_rdata
//   mem side: mem_read, mem_write, mem_addr, mem_wdata -> mem_rdata, mem_ready
interface l2_cache_2way_if #(
    parameter int ADDR_W = 28,
    parameter int LINE_W = 128
);
    logic              l2_read;
    logic              l2_write;
    logic [ADDR_W-1:0] l2_addr;
    logic [LINE_W-1:0] l2_wdata;
    logic              l2_ready;
    logic [LINE_W-1:0] l2_rdata;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  l2_read, l2_write, l2_addr, l2_wdata, mem_rdata, mem_ready,
        output l2_ready, l2_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output l2_read, l2_write, l2_addr, l2_wdata, mem_rdata, mem_ready,
        input  l2_ready, l2_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/l2_cache_way.sv
// l2_cache_way: storage for one way (valid, dirty, tag, line per set).
//   clk, reset       : clock, async active-high reset (clears everything)
//   i_idx, i_tag     : set index and tag for lookup and for writes
//   i_we             : write the indexed set: valid=1, tag=i_tag,
//                      line=i_wdata, dirty=i_wdirty
//   o_valid/o_dirty/o_tag/o_data : combinational read of the indexed set
//   o_hit            : valid && stored tag == i_tag
module l2_cache_way #(
    parameter int IDX_W  = 5,
    parameter int TAG_W  = 23,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [TAG_W-1:0]  i_tag,
    input  logic              i_we,
    input  logic [LINE_W-1:0] i_wdata,
    input  logic              i_wdirty,
    output logic              o_valid,
    output logic              o_dirty,
    output logic [TAG_W-1:0]  o_tag,
    output logic [LINE_W-1:0] o_data,
    output logic              o_hit
);
    localparam int SETS = 1 << IDX_W;

    logic [SETS-1:0]   r_valid;
    logic [SETS-1:0]   r_dirty;
    logic [TAG_W-1:0]  r_tag  [SETS];
    logic [LINE_W-1:0] r_data [SETS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            r_dirty <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_tag[s]  <= '0;
                r_data[s] <= '0;
            end
        end else if (i_we) begin
            r_valid[i_idx] <= 1'b1;
            r_dirty[i_idx] <= i_wdirty;
            r_tag[i_idx]   <= i_tag;
            r_data[i_idx]  <= i_wdata;
        end
    end

    assign o_valid = r_valid[i_idx];
    assign o_dirty = r_dirty[i_idx];
    assign o_tag   = r_tag[i_idx];
    assign o_data  = r_data[i_idx];
    assign o_hit   = o_valid && (o_tag == i_tag);

endmodule

// File: rtl/l2_cache_2way.sv
// l2_cache_2way: 2-way set-associative, write-back, write-allocate L2 cache.
//   clk, reset : clock, async active-high reset
//   bus        : l2_cache_2way_if.slave (L1 request side + memory side)
//   perf_hit   : cycles with l2_ready=1
//   perf_miss  : misses (IDLE -> WB/FILL)
//   perf_wb    : dirty victim write-backs
// Build option: define L2_PERF_CNT_EN to implement the perf counters;
// otherwise they read as 0.
module l2_cache_2way
    import l2_cache_pkg::*;
#(
    parameter int ADDR_W = 28,
    parameter int LINE_W = 128,
    parameter int IDX_W  = 5
) (
    input  logic                clk,
    input  logic                reset,
    l2_cache_2way_if.slave      bus,
    output logic [31:0]         perf_hit,
    output logic [31:0]         perf_miss,
    output logic [31:0]         perf_wb
);
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam int SETS  = 1 << IDX_W;

    state_t            r_state;
    logic [SETS-1:0]   r_lru;      // per set: way to replace next
    logic              r_victim;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [LINE_W-1:0] r_mem_wdata;

    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic              w_req_rd, w_req_wr, w_req;
    logic [NUM_WAYS-1:0] w_valid, w_dirty, w_hit, w_we;
    logic [TAG_W-1:0]  w_way_tag  [NUM_WAYS];
    logic [LINE_W-1:0] w_way_data [NUM_WAYS];
    logic              w_hit_any, w_hit_way, w_ready, w_wr_hit;
    logic              w_miss, w_fill_done, w_vict, w_vict_dirty;
    logic [LINE_W-1:0] w_wdata;
    logic              w_wdirty;

    assign w_idx    = bus.l2_addr[IDX_W-1:0];
    assign w_tag    = bus.l2_addr[ADDR_W-1:IDX_W];
    assign w_req_rd = bus.l2_read & ~bus.l2_write;
    assign w_req_wr = bus.l2_write & ~bus.l2_read;
    assign w_req    = w_req_rd | w_req_wr;

    assign w_hit_any    = |w_hit;
    assign w_hit_way    = w_hit[1];
    assign w_ready      = (r_state == S_IDLE) & w_req & w_hit_any;
    assign w_wr_hit     = w_ready & w_req_wr;
    assign w_miss       = (r_state == S_IDLE) & w_req & ~w_hit_any;
    assign w_fill_done  = (r_state == S_FILL) & bus.mem_ready;
    assign w_vict       = victim_sel(w_valid[0], w_valid[1], r_lru[w_idx]);
    assign w_vict_dirty = w_valid[w_vict] & w_dirty[w_vict];

    // Hit-writes and fills never coincide (different states), so one shared
    // write bus per way suffices; fills install clean lines.
    assign w_wdata  = w_fill_done ? bus.mem_rdata : bus.l2_wdata;
    assign w_wdirty = ~w_fill_done;
    assign w_we[0]  = (w_wr_hit & ~w_hit_way) | (w_fill_done & ~r_victim);
    assign w_we[1]  = (w_wr_hit &  w_hit_way) | (w_fill_done &  r_victim);

    for (genvar g = 0; g < NUM_WAYS; g++) begin : g_way
        l2_cache_way #(
            .IDX_W  (IDX_W),
            .TAG_W  (TAG_W),
            .LINE_W (LINE_W)
        ) u_way (
            .clk      (clk),
            .reset    (reset),
            .i_idx    (w_idx),
            .i_tag    (w_tag),
            .i_we     (w_we[g]),
            .i_wdata  (w_wdata),
            .i_wdirty (w_wdirty),
            .o_valid  (w_valid[g]),
            .o_dirty  (w_dirty[g]),
            .o_tag    (w_way_tag[g]),
            .o_data   (w_way_data[g]),
            .o_hit    (w_hit[g])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_lru       <= '0;
            r_victim    <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_ready) begin
                        r_lru[w_idx] <= ~w_hit_way;
                    end else if (w_miss) begin
                        r_victim <= w_vict;
                        if (w_vict_dirty) begin
                            r_mem_write <= 1'b1;
                            r_mem_addr  <= {w_way_tag[w_vict], w_idx};
                            r_mem_wdata <= w_way_data[w_vict];
                            r_state     <= S_WB;
                        end else begin
                            r_mem_read <= 1'b1;
                            r_mem_addr <= bus.l2_addr;
                            r_state    <= S_FILL;
                        end
                    end
                end
                S_WB: begin
                    if (bus.mem_ready) begin
                        r_mem_write <= 1'b0;
                        r_mem_read  <= 1'b1;
                        r_mem_addr  <= bus.l2_addr;
                        r_state     <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (bus.mem_ready) begin
                        r_mem_read      <= 1'b0;
                        r_lru[w_idx]    <= ~r_victim;
                        r_state         <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.l2_ready  = w_ready;
    assign bus.l2_rdata  = (w_ready & w_req_rd) ? w_way_data[w_hit_way] : '0;
    assign bus.mem_read  = r_mem_read;
    assign bus.mem_write = r_mem_write;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;

`ifdef L2_PERF_CNT_EN
    logic [31:0] r_perf_hit, r_perf_miss, r_perf_wb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_hit  <= '0;
            r_perf_miss <= '0;
            r_perf_wb   <= '0;
        end else begin
            if (w_ready)               r_perf_hit  <= r_perf_hit + 32'd1;
            if (w_miss)                r_perf_miss <= r_perf_miss + 32'd1;
            if (w_miss & w_vict_dirty) r_perf_wb   <= r_perf_wb + 32'd1;
        end
    end

    assign perf_hit  = r_perf_hit;
    assign perf_miss = r_perf_miss;
    assign perf_wb   = r_perf_wb;
`else
    assign perf_hit  = '0;
    assign perf_miss = '0;
    assign perf_wb   = '0;
`endif

endmodule

// File: tb/tb_l2_cache_2way.sv
module tb_l2_cache_2way;

    localparam int ADDR_W = 28;
    localparam int LINE_W = 128;

`ifdef L2_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [127:0] DA = {4{32'hAAAA_0001}};
    localparam logic [127:0] DB = {4{32'hBBBB_0002}};
    localparam logic [127:0] DC = {4{32'hCCCC_0003}};
    localparam logic [127:0] DD = {4{32'hDDDD_0004}};
    localparam logic [127:0] DE = {4{32'hEEEE_0005}};
    localparam logic [127:0] DF = {4{32'hFFFF_0006}};
    localparam logic [127:0] DG = {4{32'h1234_0007}};
    localparam logic [127:0] DH = {4{32'h5678_0008}};
    localparam logic [127:0] DK = {4{32'h9ABC_0009}};

    logic        clk;
    logic        reset;
    logic [31:0] perf_hit, perf_miss, perf_wb;
    int          n_err;
    int          n_checks;

    l2_cache_2way_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    l2_cache_2way #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .IDX_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .perf_hit  (perf_hit),
        .perf_miss (perf_miss),
        .perf_wb   (perf_wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                       input logic [LINE_W-1:0] d);
        bus.l2_read  = rd;
        bus.l2_write = wr;
        bus.l2_addr  = a;
        bus.l2_wdata = d;
    endtask

    // Memory completes its access in the lat-th cycle after the request appeared.
    task automatic mem_resp(input int lat, input logic [LINE_W-1:0] d);
        for (int i = 0; i < lat - 1; i++) step();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = d;
        step();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_err    = 0;
        n_checks = 0;
        reset    = 1'b1;
        req(1'b0, 1'b0, '0, '0);
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_read",  128'(bus.mem_read), 128'(0));
        chk("rst_mem_write", 128'(bus.mem_write), 128'(0));
        chk("rst_mem_addr",  128'(bus.mem_addr), 128'(0));
        chk("rst_mem_wdata", bus.mem_wdata, 128'(0));
        chk("rst_ready",     128'(bus.l2_ready), 128'(0));
        chk("rst_perf_miss", 128'(perf_miss), 128'(0));
        reset = 1'b0;
        step();

        // cold read miss, memory answers in the 3rd cycle
        req(1'b1, 1'b0, 28'h20, '0);
        #1;
        chk("cold_ready0", 128'(bus.l2_ready), 128'(0));
        chk("cold_rdata0", bus.l2_rdata, 128'(0));
        chk("cold_noreq_yet", 128'(bus.mem_read), 128'(0));
        step();
        chk("cold_mem_read", 128'(bus.mem_read), 128'(1));
        chk("cold_mem_write", 128'(bus.mem_write), 128'(0));
        chk("cold_mem_addr", 128'(bus.mem_addr), 128'(28'h20));
        step();
        chk("cold_mem_hold", 128'(bus.mem_read), 128'(1));
        mem_resp(2, DA);
        chk("cold_ready", 128'(bus.l2_ready), 128'(1));
        chk("cold_rdata", bus.l2_rdata, DA);
        chk("cold_mem_drop", 128'(bus.mem_read), 128'(0));
        step();
        chk("cold_perf_miss", 128'(perf_miss), PERF ? 128'(1) : 128'(0));
        req(1'b0, 1'b0, '0, '0);

        // second line of set 0 goes to way1, then both hit with no traffic
        step();
        req(1'b1, 1'b0, 28'h40, '0);
        #1;
        chk("w1_ready0", 128'(bus.l2_ready), 128'(0));
        step();
        chk("w1_mem_read", 128'(bus.mem_read), 128'(1));
        chk("w1_mem_addr", 128'(bus.mem_addr), 128'(28'h40));
        mem_resp(1, DD);
        chk("w1_rdata", bus.l2_rdata, DD);
        step();
        req(1'b1, 1'b0, 28'h20, '0);
        #1;
        chk("hit20_ready", 128'(bus.l2_ready), 128'(1));
        chk("hit20_rdata", bus.l2_rdata, DA);
        step();
        req(1'b1, 1'b0, 28'h40, '0);
        #1;
        chk("hit40_ready", 128'(bus.l2_ready), 128'(1));
        chk("hit40_rdata", bus.l2_rdata, DD);
        step();
        req(1'b0, 1'b0, '0, '0);
        #1;
        chk("hits_no_mem_read", 128'(bus.mem_read), 128'(0));
        chk("hits_no_mem_write", 128'(bus.mem_write), 128'(0));

        // dirty LRU eviction: write B to 0x20, touch 0x40, read 0x60
        step();
        req(1'b0, 1'b1, 28'h20, DB);
        #1;
        chk("wrhit_ready", 128'(bus.l2_ready), 128'(1));
        chk("wrhit_rdata", bus.l2_rdata, 128'(0));
        step();
        req(1'b1, 1'b0, 28'h40, '0);
        #1;
        chk("touch40_rdata", bus.l2_rdata, DD);
        step();
        req(1'b1, 1'b0, 28'h60, '0);
        #1;
        chk("ev_ready0", 128'(bus.l2_ready), 128'(0));
        step();
        chk("ev_mem_write", 128'(bus.mem_write), 128'(1));
        chk("ev_mem_read0", 128'(bus.mem_read), 128'(0));
        chk("ev_wb_addr", 128'(bus.mem_addr), 128'(28'h20));
        chk("ev_wb_data", bus.mem_wdata, DB);
        mem_resp(2, '0);
        chk("ev_wb_drop", 128'(bus.mem_write), 128'(0));
        chk("ev_fill_read", 128'(bus.mem_read), 128'(1));
        chk("ev_fill_addr", 128'(bus.mem_addr), 128'(28'h60));
        mem_resp(2, DE);
        chk("ev_rdata", bus.l2_rdata, DE);
        step();
        chk("ev_perf_wb", 128'(perf_wb), PERF ? 128'(1) : 128'(0));
        chk("ev_perf_miss", 128'(perf_miss), PERF ? 128'(3) : 128'(0));
        chk("ev_perf_hit", 128'(perf_hit), PERF ? 128'(7) : 128'(0));
        req(1'b0, 1'b0, '0, '0);

        // write miss to clean victim (way1 holds clean 0x40)
        step();
        req(1'b0, 1'b1, 28'h80, DC);
        #1;
        chk("wm_ready0", 128'(bus.l2_ready), 128'(0));
        step();
        chk("wm_mem_read", 128'(bus.mem_read), 128'(1));
        chk("wm_no_write", 128'(bus.mem_write), 128'(0));
        chk("wm_mem_addr", 128'(bus.mem_addr), 128'(28'h80));
        mem_resp(1, DF);
        chk("wm_ready", 128'(bus.l2_ready), 128'(1));
        chk("wm_rdata_zero", bus.l2_rdata, 128'(0));
        step();
        req(1'b1, 1'b0, 28'h80, '0);
        #1;
        chk("wm_readback", bus.l2_rdata, DC);
        step();

        // 0xA0 replaces clean way0; 0xC0 then evicts the dirty write-miss line
        req(1'b1, 1'b0, 28'hA0, '0);
        step();
        chk("a0_clean_fill", 128'(bus.mem_read), 128'(1));
        chk("a0_no_wb", 128'(bus.mem_write), 128'(0));
        mem_resp(1, DK);
        chk("a0_rdata", bus.l2_rdata, DK);
        step();
        req(1'b1, 1'b0, 28'hC0, '0);
        step();
        chk("c0_wb", 128'(bus.mem_write), 128'(1));
        chk("c0_wb_addr", 128'(bus.mem_addr), 128'(28'h80));
        chk("c0_wb_data", bus.mem_wdata, DC);
        mem_resp(1, '0);
        chk("c0_fill_addr", 128'(bus.mem_addr), 128'(28'hC0));
        mem_resp(1, DH);
        chk("c0_rdata", bus.l2_rdata, DH);
        step();
        req(1'b0, 1'b0, '0, '0);

        // reset in the middle of a fill
        step();
        req(1'b1, 1'b0, 28'hA1, '0);
        step();
        chk("rf_mem_read", 128'(bus.mem_read), 128'(1));
        reset = 1'b1;
        #1;
        chk("rf_async_drop", 128'(bus.mem_read), 128'(0));
        chk("rf_async_addr", 128'(bus.mem_addr), 128'(0));
        step();
        reset = 1'b0;
        #1;
        chk("rf_miss_again", 128'(bus.l2_ready), 128'(0));
        step();
        chk("rf_refetch", 128'(bus.mem_read), 128'(1));
        chk("rf_refetch_addr", 128'(bus.mem_addr), 128'(28'hA1));
        mem_resp(1, DG);
        chk("rf_rdata", bus.l2_rdata, DG);
        step();
        chk("rf_perf_miss", 128'(perf_miss), PERF ? 128'(1) : 128'(0));

        // both strobes high: no-op; stray mem_ready in IDLE ignored
        req(1'b1, 1'b1, 28'hA1, DB);
        bus.mem_ready = 1'b1;
        #1;
        chk("both_ready", 128'(bus.l2_ready), 128'(0));
        chk("both_rdata", bus.l2_rdata, 128'(0));
        step();
        chk("both_no_read", 128'(bus.mem_read), 128'(0));
        chk("both_no_write", 128'(bus.mem_write), 128'(0));
        step();
        chk("both_still_idle", 128'(bus.mem_read | bus.mem_write), 128'(0));
        bus.mem_ready = 1'b0;
        req(1'b1, 1'b0, 28'hA1, '0);
        #1;
        chk("both_after_hit", 128'(bus.l2_ready), 128'(1));
        chk("both_after_data", bus.l2_rdata, DG);
        step();
        req(1'b0, 1'b0, '0, '0);
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/l2_cache_2way.md
Name: l2_cache_2way

Overview:
- Parametrised 2-way set-associative, write-back, write-allocate L2 cache between the L1 caches and main memory.
- Generalises the direct-mapped L2: configurable set count, address width and line width; per-set LRU replacement; dirty victim write-back; optional performance counters.
- Line-granular interface on both sides; one request in flight.

Parameters:
- ADDR_W, 28, line address width (L1 and memory side).
- LINE_W, 128, bits per cache line.
- IDX_W, 5, set index bits; SETS = 2**IDX_W; TAG_W = ADDR_W-IDX_W.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- l2_read  in  1  line read request
- l2_write  in  1  line write request
- l2_addr  in  ADDR_W  line address; [IDX_W-1:0] = set, upper bits = tag
- l2_wdata  in  LINE_W  write line
- l2_ready  out  1  request completes this cycle
- l2_rdata  out  LINE_W  read line, valid when l2_ready && l2_read
- mem_read  out  1  memory line read
- mem_write  out  1  memory line write
- mem_addr  out  ADDR_W  memory line address
- mem_wdata  out  LINE_W  victim line
- mem_rdata  in  LINE_W  fill data, valid with mem_ready
- mem_ready  in  1  memory completes current access
- perf_hit, perf_miss, perf_wb  out  32 each  counters (see Optional Feature)

Behaviour:
- Reset (async): all valid, dirty and LRU bits 0; tags and data 0; state IDLE; mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0. Counters 0.
- Request: exactly one of l2_read/l2_write high. Both high, or neither: no-op, l2_ready=0, no state change. Upstream holds addr/wdata stable until l2_ready.
- Hit = valid && tag match in either way of the indexed set. Both ways matching cannot occur.
- IDLE + hit: l2_ready=1 combinationally in the same cycle.
  - Read: l2_rdata = hit way's line.
  - Write: line <= l2_wdata and dirty <= 1 at the clock edge.
  - LRU(set) <= other way.
- l2_rdata = 0 whenever l2_ready=0 or the request is a write.
- IDLE + miss: l2_ready=0. Victim = first invalid way (way0 first), else the LRU way.
  - Victim valid && dirty: mem_write=1, mem_addr={victim tag, set}, mem_wdata=victim line; go to WB.
  - Otherwise: mem_read=1, mem_addr=l2_addr; go to FILL.
  - All memory outputs are registered: asserted the cycle after miss detection.
- Victim way is latched at miss and used through FILL.
- WB: l2_ready=0; hold outputs until mem_ready.
  - On mem_ready: mem_write=0, mem_read=1, mem_addr=l2_addr; go to FILL.
- FILL: l2_ready=0; hold until mem_ready.
  - On mem_ready: victim way gets tag, line=mem_rdata, valid=1, dirty=0. LRU(set) <= other way. mem_read=0; go to IDLE.
- The next cycle is a hit. A write miss completes there by writing the line and setting dirty.
- Latency:
  - Hit: 0 cycles.
  - Clean miss: 1 + memory read cycles + 1.
  - Dirty miss adds the memory write cycles.
- mem_read and mem_write are never high together. Each stays high continuously until the cycle mem_ready is sampled high, then drops the next cycle.
- mem_ready outside WB/FILL is ignored.
- Reset mid-miss: immediate return to the reset state. An in-flight memory access is abandoned.

Optional Feature:
- L2_PERF_CNT_EN defined: perf_hit counts cycles with l2_ready=1, including the post-fill completion hit. perf_miss counts IDLE->WB/FILL transitions. perf_wb counts WB entries. All 32-bit, wrap at 2**32, cleared by reset.
- Undefined: counter logic omitted, perf_* tied to 0, ports retained.

Decomposition:
- Package l2_cache_pkg: state enum (S_IDLE, S_WB, S_FILL), way count localparam, victim-select function.
- Sub-module l2_cache_way: one way's valid/dirty/tag/data arrays, with:
  - registered write port;
  - combinational read by index;
  - tag-compare hit output.
- Top instantiates it twice and holds the FSM, LRU bits and memory-side registers.

Test Plan:
- Cold read 0x0000020, mem_ready after 3 cycles with data A -> mem_read pulse with addr 0x0000020, then l2_ready=1 with l2_rdata=A; perf_miss=1.
- Read 0x0000020 then 0x0000040 (same set 0) -> second fills way1; rereading both gives 0-cycle hits, no memory traffic.
- Write B to 0x0000020 (hit), read 0x0000040, then read 0x0000060 -> victim is way0 (LRU):
  - mem_write with addr 0x0000020, data B;
  - then mem_read 0x0000060;
  - perf_wb=1.
- Write miss C to 0x0000080 on a clean set -> fill only, no mem_write; the following cycle l2_ready=1 and the line reads back C.
- Assert reset during FILL -> mem_read=0 immediately; the next read of the same address misses again.
- l2_read and l2_write both high for 2 cycles -> l2_ready=0, no memory request, state unchanged.
